lsu_ctrl: RTL

Load/store control unit for the RV32I datapath. Accepts one memory instruction at a time from the execute stage and generates byte-lane masks and replicated store data. Runs a req/ack handshake with data memory, then aligns and sign- or zero-extends load data. Its `o_ld_data` output is the load-result input of the writeback 8-to-1 result mux.

---
 rtl/lsu_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- RV32I load/store control unit.
//
// Takes one memory instruction at a time from the execute stage, builds the
// byte-lane mask and lane-replicated store data, runs a req/ack handshake
// with data memory, then aligns and sign/zero-extends the returned load word.
// Misaligned or unsupported operations complete immediately with o_err and
// never touch memory.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_valid / o_ready       request handshake from execute (ready only in IDLE)
//   i_is_load, i_is_store   operation type (load wins if both are set)
//   i_funct3                width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_addr, i_wdata         effective byte address, store source (rs2)
//   o_mem_req/we/addr/wdata/bmask   memory request, held stable until ack
//   i_mem_ack, i_mem_rdata  memory completion, read data valid with ack
//   o_done, o_err           one-cycle completion pulse, error flag
//   o_ld_data               extended load result for the writeback mux
module lsu_ctrl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_ld_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bmask_q, bmask_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;
  logic [31:0] ld_data_q, ld_data_d;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful while IDLE)
  // ---------------------------------------------------------------------------
  logic        req_fire;
  logic        req_illegal;
  logic        req_misalign;
  logic [3:0]  req_bmask;
  logic [31:0] req_wdata;

  assign req_fire = i_valid & (i_is_load | i_is_store);

  // Loads allow 000/001/010/100/101; stores only 000/001/010.
  assign req_illegal = i_is_load ? ((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11))
                                 : (i_funct3 >= 3'b011);

  assign req_misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    req_bmask = 4'b1111;
    req_wdata = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        req_bmask = 4'b0001 << i_addr[1:0];
        req_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        req_bmask = 4'b0011 << i_addr[1:0];
        req_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the memory word using the captured offset/width
  // ---------------------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign ld_byte = i_mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    ld_ext = i_mem_rdata;
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = i_mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bmask_d   = bmask_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    err_d     = err_q;
    ld_data_d = ld_data_q;

    o_ready   = 1'b0;
    o_mem_req = 1'b0;
    o_done    = 1'b0;
    o_err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (req_fire) begin
          we_d     = ~i_is_load;
          addr_d   = {i_addr[31:2], 2'b00};
          wdata_d  = i_is_load ? 32'd0 : req_wdata;
          bmask_d  = req_bmask;
          funct3_d = i_funct3;
          off_d    = i_addr[1:0];
          err_d    = req_illegal | req_misalign;
          if (req_illegal | req_misalign) begin
            // Error completes without a memory access; the result reads 0.
            ld_data_d = 32'd0;
            state_d   = S_RESP;
          end else begin
            state_d   = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          ld_data_d = we_q ? 32'd0 : ld_ext;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        o_done  = 1'b1;
        o_err   = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_bmask = bmask_q;
  assign o_ld_data   = ld_data_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the captured request registers are reset along with the FSM because
  // they drive the memory outputs and o_ld_data directly, which must read 0
  // out of reset. Non-blocking assignments keep all registers updating from
  // the same pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      bmask_q   <= 4'd0;
      funct3_q  <= 3'd0;
      off_q     <= 2'd0;
      err_q     <= 1'b0;
      ld_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bmask_q   <= bmask_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
    end
  end

endmodule
